// File: rtl/pipeline_fetch.sv
// pipeline_fetch: instruction-fetch stage owning the PC, a req/ack imem port, a one-word skid
// buffer and the IF/ID register. Define PSRV_FETCH_PERF_EN to add fetch/bubble perf counters.
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcsrc_o,
  output logic        valid_o
`ifdef PSRV_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] pending_pc, pending_pc_nxt;
  logic [31:0] skid, skid_nxt;
  logic [31:0] instr_p1, pc_p1;
  logic        vld_p1;
  logic        load_p1, load_vld_p1;
  logic [31:0] load_instr_p1, load_pc_p1;
  logic        ack;
  logic [31:0] target;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign target      = word_align(redirect_pc_i);
  assign imem_req_o  = (state != HOLD) & ~rst_i;
  assign imem_addr_o = word_align(fetch_pc);
  // An ack only means something while a request is actually on the port.
  assign ack         = imem_ack_i & imem_req_o;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    pending_pc_nxt = pending_pc;
    skid_nxt       = skid;
    load_p1        = 1'b0;
    load_vld_p1    = 1'b0;
    load_instr_p1  = instr_p1;
    load_pc_p1     = pc_p1;
    unique case (state)
      REQ: begin
        if (flush_i) begin
          load_p1 = 1'b1;
          if (ack) begin
            fetch_pc_nxt = target;
          end else begin
            pending_pc_nxt = target;
            state_nxt      = DRAIN;
          end
        end else if (ack) begin
          if (!stall_i) begin
            load_p1       = 1'b1;
            load_vld_p1   = 1'b1;
            load_instr_p1 = imem_data_i;
            load_pc_p1    = fetch_pc;
            fetch_pc_nxt  = next_pc(fetch_pc);
          end else begin
            skid_nxt  = imem_data_i;
            state_nxt = HOLD;
          end
        end else if (!stall_i) begin
          load_p1 = 1'b1;
        end
      end
      HOLD: begin
        if (flush_i) begin
          load_p1      = 1'b1;
          fetch_pc_nxt = target;
          state_nxt    = REQ;
        end else if (!stall_i) begin
          load_p1       = 1'b1;
          load_vld_p1   = 1'b1;
          load_instr_p1 = skid;
          load_pc_p1    = fetch_pc;
          fetch_pc_nxt  = next_pc(fetch_pc);
          state_nxt     = REQ;
        end
      end
      DRAIN: begin
        if (flush_i) begin
          load_p1        = 1'b1;
          pending_pc_nxt = target;
        end else if (!stall_i) begin
          load_p1 = 1'b1;
        end
        // The abandoned word is dropped; a redirect in the same cycle still wins.
        if (ack) begin
          fetch_pc_nxt = flush_i ? target : pending_pc;
          state_nxt    = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  // ---- IF/ID register (p1) and fetch control ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
      pc_p1    <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (load_p1) begin
        vld_p1 <= load_vld_p1;
        pc_p1  <= load_pc_p1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pending_pc <= pending_pc_nxt;
    skid       <= skid_nxt;
    if (load_p1) instr_p1 <= load_instr_p1;
  end

  assign valid_o       = vld_p1;
  assign instruction_o = vld_p1 ? instr_p1 : NOP_INSTR;
  assign pc_o          = pc_p1;
  assign pcsrc_o       = next_pc(pc_p1);

`ifdef PSRV_FETCH_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o  <= 32'd0;
      perf_bubble_cnt_o <= 32'd0;
    end else if (load_p1) begin
      if (load_vld_p1) perf_fetch_cnt_o  <= perf_fetch_cnt_o + 32'd1;
      else             perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: bench for pipeline_fetch with a latency-configurable instruction memory,
// a directed vector table, corner-case sequences and a random phase against a stream model.
`timescale 1ns/1ps
module tb_pipeline_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [31:0] redirect = 32'h0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] instr, pc, pcsrc;
  logic        valid;
`ifdef PSRV_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_bubble;
`endif

  int          tests = 0, fails = 0;
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;
  logic [31:0] key = 32'h0;
  int          wait_cnt = 0, cur_lat = 0;
  logic        pre_req, pre_ack;
  logic [31:0] pre_addr;

  logic        p_valid, r_st, r_fl, found;
  logic [31:0] p_pc, p_instr, r_rd, exp_next;
  int          delivered;

  always #5 clk = ~clk;

  pipeline_fetch dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .redirect_pc_i(redirect),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_data_i(imem_data), .instruction_o(instr), .pc_o(pc), .pcsrc_o(pcsrc),
    .valid_o(valid)
`ifdef PSRV_FETCH_PERF_EN
    , .perf_fetch_cnt_o(perf_fetch), .perf_bubble_cnt_o(perf_bubble)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  // Memory: acks after 'latency' waiting cycles of a held request; resets with the DUT.
  assign imem_ack  = imem_req && (wait_cnt >= (rand_lat ? cur_lat : fixed_lat));
  assign imem_data = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      cur_lat  <= 0;
    end else if (imem_ack) begin
      wait_cnt <= 0;
      cur_lat  <= $urandom_range(0, 3);
    end else if (imem_req) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [31:0] epc);
    chk({name, "_valid"}, {31'd0, valid}, {31'd0, ev});
    if (ev) begin
      chk({name, "_pc"}, pc, epc);
      chk({name, "_instr"}, instr, mem_word(epc));
    end else begin
      chk({name, "_nop"}, instr, NOP);
    end
    chk({name, "_pcsrc"}, pcsrc, pc + 32'd4);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_valid"}, {31'd0, valid}, 32'd0);
    chk({name, "_instr"}, instr, NOP);
    chk({name, "_pc"}, pc, 32'h0);
    chk({name, "_pcsrc"}, pcsrc, 32'h4);
    chk({name, "_req"}, {31'd0, imem_req}, 32'd0);
`ifdef PSRV_FETCH_PERF_EN
    chk({name, "_perf_fetch"}, perf_fetch, 32'd0);
    chk({name, "_perf_bubble"}, perf_bubble, 32'd0);
`endif
  endtask

  // Called at posedge+1; samples the pre-edge port state, then advances one edge.
  task automatic drive(input logic st, input logic fl, input logic [31:0] rd);
    stall = st; flush = fl; redirect = rd;
    #2;
    pre_req = imem_req; pre_ack = imem_ack; pre_addr = imem_addr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int lat, input bit rl, input logic [31:0] k);
    stall = 1'b0; flush = 1'b0; redirect = 32'h0;
    fixed_lat = lat; rand_lat = rl; key = k;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic        fl;
    logic [31:0] rd;
    logic        ev;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl[17];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hC};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h10};
    tbl[7]  = '{1'b0, 1'b1, 32'h103,       1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h100};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h104};
    tbl[10] = '{1'b1, 1'b1, 32'h40,        1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h44};
    tbl[14] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC};
    tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0};

    // Zero-wait memory, word = address.
    do_reset(0, 1'b0, 32'h0);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].rd);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc);
    end
`ifdef PSRV_FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch, 32'd11);
    chk("perf_bubble_cnt", perf_bubble, 32'd3);
`endif

    // Three-cycle ack latency: valid pattern 0,0,0,1 with a stable address.
    do_reset(3, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      chk($sformatf("lat3_addr%0d", i), pre_addr, (i < 4) ? 32'h0 : 32'h4);
      chk_out($sformatf("lat3_%0d", i), (i % 4) == 3, (i < 4) ? 32'h0 : 32'h4);
    end

    // Stall for 4 cycles while the 0x10 word is acked.
    do_reset(0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      chk_out($sformatf("pre_stall%0d", i), 1'b1, 32'(4 * i));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (i > 0) chk($sformatf("hold_req%0d", i), {31'd0, pre_req}, 32'd0);
      chk_out($sformatf("stall%0d", i), 1'b1, 32'hC);
    end
    drive(1'b0, 1'b0, 32'h0);
    chk_out("unstall0", 1'b1, 32'h10);
    drive(1'b0, 1'b0, 32'h0);
    chk_out("unstall1", 1'b1, 32'h14);

    // Redirect to 0x103 during a 3-cycle wait at 0x20.
    do_reset(3, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (pre_req && pre_addr == 32'h20) found = 1'b1;
    end
    chk("f103_reach_0x20", {31'd0, found}, 32'd1);
    drive(1'b0, 1'b1, 32'h103);
    chk_out("f103_flush", 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (pre_addr != 32'h20) begin
        found = 1'b1;
        chk("f103_next_addr", pre_addr, 32'h100);
      end else begin
        chk_out("f103_drain", 1'b0, 32'h0);
      end
    end
    chk("f103_drain_done", {31'd0, found}, 32'd1);
    found = valid;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      found = valid;
    end
    chk_out("f103_target", 1'b1, 32'h100);

    // Flush together with stall while in HOLD.
    do_reset(0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    chk_out("hold_enter", 1'b1, 32'h4);
    drive(1'b1, 1'b1, 32'h80);
    chk("hold_flush_req", {31'd0, pre_req}, 32'd0);
    chk_out("hold_flush", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    chk("hold_flush_addr", pre_addr, 32'h80);
    chk_out("hold_flush_t0", 1'b1, 32'h80);
    drive(1'b0, 1'b0, 32'h0);
    chk_out("hold_flush_t1", 1'b1, 32'h84);

    // Two flushes while draining: the later target wins.
    do_reset(3, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h200);
    chk_out("drain2_f1", 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h300);
    chk("drain2_hold_addr", pre_addr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (pre_addr != 32'h0) begin
        found = 1'b1;
        chk("drain2_next_addr", pre_addr, 32'h300);
      end
    end
    chk("drain2_done", {31'd0, found}, 32'd1);
    found = valid;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      found = valid;
    end
    chk_out("drain2_target", 1'b1, 32'h300);

    // Asynchronous reset in the middle of an outstanding request.
    do_reset(2, 1'b0, 32'h0000_FFFF);
    repeat (4) drive(1'b0, 1'b0, 32'h0);
    #3 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      chk($sformatf("restart_addr%0d", i), pre_addr, 32'h0);
      chk_out($sformatf("restart%0d", i), i == 2, 32'h0);
    end

    // Random stall/flush/latency against an in-order stream model.
    do_reset(0, 1'b1, 32'hA5C3_5A3C);
    exp_next = 32'h0;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      p_valid = valid; p_pc = pc; p_instr = instr;
      r_st = ($urandom_range(0, 99) < 30);
      r_fl = ($urandom_range(0, 99) < 6);
      r_rd = $urandom;
      drive(r_st, r_fl, r_rd);
      if (pre_req && !pre_ack) begin
        chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_held", imem_addr, pre_addr);
      end
      if (r_fl) begin
        chk("rnd_flush_valid", {31'd0, valid}, 32'd0);
        exp_next = r_rd & 32'hFFFF_FFFC;
      end else if (r_st) begin
        chk("rnd_stall_frozen", {valid, pc, instr}, {p_valid, p_pc, p_instr});
      end else if (valid) begin
        chk("rnd_pc", pc, exp_next);
        chk("rnd_instr", instr, mem_word(exp_next));
        exp_next = exp_next + 32'd4;
        delivered++;
      end
      chk("rnd_pcsrc", pcsrc, pc + 32'd4);
      if (!valid) chk("rnd_nop", instr, NOP);
    end
    chk("rnd_progress", {31'd0, delivered >= 150}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
